// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB requester: valid/ready command in, SETUP/ACCESS with timeout, valid/ready response out
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;

    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              busy_q, busy_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        busy_d        = busy_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                // pready takes priority over an expiring timeout in the same cycle
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else if (TO_EN) begin
                    if (cnt_q == TO_LAST) begin
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_valid_d   = 1'b1;
                        state_d       = S_RESP;
                    end else begin
                        cnt_d = cnt_q + TO_W'(1);
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d       = S_IDLE;
                cnt_d         = '0;
                cmd_ready_d   = 1'b0;
                rsp_valid_d   = 1'b0;
                rsp_rdata_d   = '0;
                rsp_err_d     = 1'b0;
                rsp_timeout_d = 1'b0;
                busy_d        = 1'b0;
                psel_d        = 1'b0;
                penable_d     = 1'b0;
                pwrite_d      = 1'b0;
                paddr_d       = '0;
                pwdata_d      = '0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
APB requester that sits directly upstream of the team's APB RAM slave. It accepts single read/write commands on a valid/ready command port and runs the APB SETUP/ACCESS phases, waiting through slave wait states. It returns read data and error status on a valid/ready response port. A programmable timeout ends a transfer whose slave never asserts pready.

Parameters:
ADDR_W, 32, width of cmd_addr and paddr
DATA_W, 32, width of write/read data
TIMEOUT_CYCLES, 16, maximum ACCESS cycles allowed without pready; 0 disables the timeout
TO_W, 8, width of the timeout counter; TIMEOUT_CYCLES must be less than 2^TO_W

Ports:
pclk  in  1  clock; all logic on rising edge
preset  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data; 0 for writes and for all errors
rsp_err  out  1  pslverr was seen, or a timeout occurred
rsp_timeout  out  1  transfer ended by timeout
busy  out  1  high in every state except IDLE
psel, penable, pwrite  out  1 each  APB control
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- All outputs are registered. Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; timeout counter=0; state=IDLE.
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1 (goes high the cycle after reset deasserts).
  - On accept: latch write/addr/wdata into pwrite/paddr/pwdata; psel<=1, penable<=0, cmd_ready<=0; go to SETUP.
- SETUP: lasts exactly 1 cycle. penable<=1; clear the timeout counter; go to ACCESS.
- ACCESS:
  - psel, penable, pwrite, paddr and pwdata are held stable.
  - pready is sampled at each rising edge.
  - On pready=1: psel<=0, penable<=0; rsp_err<=pslverr; rsp_timeout<=0; rsp_rdata<=(read && !pslverr) ? prdata : 0; rsp_valid<=1; go to RESP.
  - Otherwise, when TIMEOUT_CYCLES!=0, the counter increments. If the counter reaches TIMEOUT_CYCLES-1 while pready=0: drop psel/penable, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0, rsp_valid<=1, go to RESP.
  - pready and timeout in the same cycle: pready wins.
- RESP:
  - rsp_valid and the response data are held until rsp_ready=1.
  - On handshake: rsp_valid<=0, cmd_ready<=1, go to IDLE.
- Throughput: one transfer in flight. Minimum of 2 idle-bus cycles between transfers (RESP plus IDLE).
- Latency:
  - Zero-wait slave: psel rises the cycle after accept, penable one cycle later, and rsp_valid the cycle after the pready edge.
  - Accept to rsp_valid = 3 edges + number of wait states.
  - The RAM slave inserts 1 wait state, giving 4 edges.
- prdata is X-tolerant: it is never propagated on pslverr, so an X from the slave cannot reach rsp_rdata.
- Reset mid-transfer (any state): all outputs return to their reset values on the next edge. No response is produced for the aborted command.
- No address range check is made here; range errors arrive via pslverr.
- An unused state encoding returns to IDLE with reset output values.

Test Plan:
1. Write 0xDEADBEEF to addr 5, then read addr 5, rsp_ready tied 1 -> write response rsp_err=0, rsp_rdata=0. Read response rsp_rdata=0xDEADBEEF. psel high for 3 cycles per transfer against the RAM slave.
2. Read addr 40 (out of range) -> rsp_err=1, rsp_timeout=0, rsp_rdata=0 (not X). Bus idle after completion.
3. Slave model holds pready low for 5 ACCESS cycles -> psel/penable/paddr/pwdata stable throughout. Response valid 8 edges after accept.
4. pready never asserted, TIMEOUT_CYCLES=16 -> psel drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. The next command proceeds normally.
5. rsp_ready held low 10 cycles after a read of 0x12345678 -> rsp_valid and data held stable and cmd_ready=0 for all 10 cycles. The next command is accepted only after the handshake.
6. preset asserted in the ACCESS cycle of a write -> psel=penable=0 and rsp_valid=0 the next edge. No response is produced, and cmd_ready=1 one cycle after preset falls.
